// File: rtl/instr_fetch_seq_if.sv
// rtl/instr_fetch_seq_if.sv - instruction-memory read bus between fetch unit and memory
interface instr_fetch_seq_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 15
);
   logic               im_req;
   logic [ADDR_W-1:0]  im_addr;
   logic [INSTR_W-1:0] im_rdata;
   logic               im_ack;

   modport master (output im_req, output im_addr, input im_rdata, input im_ack);
   modport slave  (input im_req, input im_addr, output im_rdata, output im_ack);
endinterface

// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - PC owner, instruction fetch and EXEC strobe sequencer
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_seq #(
   parameter int                ADDR_W   = 8,
   parameter int                OPC_W    = 7,
   parameter int                LIT_W    = 8,
   parameter int                INSTR_W  = 15,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [OPC_W-1:0]  HALT_OPC = 7'b1111111,
   parameter int                TIMEOUT  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_fetch_seq_if.master    im,
   output logic [OPC_W-1:0]     opcode,
   output logic [LIT_W-1:0]     literal,
   output logic                 instr_valid,
   input  logic                 pc_load,
   input  logic                 flags_we,
   input  logic                 alu_z,
   input  logic                 alu_n,
   input  logic                 alu_c,
   input  logic                 alu_v,
   output logic                 Z,
   output logic                 N,
   output logic                 C,
   output logic                 V,
   output logic [ADDR_W-1:0]    pc,
   output logic                 halted,
   output logic                 fetch_err
);

   if (INSTR_W != OPC_W + LIT_W || TIMEOUT < 1 || ADDR_W > LIT_W) begin : g_bad_params
      $error("instr_fetch_seq: inconsistent field widths or TIMEOUT");
   end

   typedef enum logic [1:0] {
      S_START,
      S_FETCH,
      S_EXEC,
      S_HALT
   } state_t;

   state_t state;

   assign im.im_addr = pc;

`ifdef FETCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;
`else
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_START;
         pc          <= RESET_PC;
         opcode      <= '0;
         literal     <= '0;
         Z           <= 1'b0;
         N           <= 1'b0;
         C           <= 1'b0;
         V           <= 1'b0;
         instr_valid <= 1'b0;
         im.im_req   <= 1'b0;
         halted      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         fetch_err   <= 1'b0;
         tmo_cnt     <= '0;
`endif
      end else begin
         case (state)
            S_START: begin
               state     <= S_FETCH;
               im.im_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
               tmo_cnt   <= '0;
`endif
            end
            S_FETCH: begin
               if (im.im_ack) begin
                  opcode      <= im.im_rdata[INSTR_W-1:LIT_W];
                  literal     <= im.im_rdata[LIT_W-1:0];
                  im.im_req   <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= S_EXEC;
               end
`ifdef FETCH_TIMEOUT_EN
               // pc is left pointing at the address that never answered
               else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  fetch_err <= 1'b1;
                  halted    <= 1'b1;
                  im.im_req <= 1'b0;
                  state     <= S_HALT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            S_EXEC: begin
               instr_valid <= 1'b0;
               if (pc_load) begin
                  pc <= literal[ADDR_W-1:0];
               end else begin
                  pc <= pc + 1'b1;
               end
               if (flags_we) begin
                  Z <= alu_z;
                  N <= alu_n;
                  C <= alu_c;
                  V <= alu_v;
               end
               // the halting instruction still commits its pc and flag updates
               if (opcode == HALT_OPC) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  im.im_req <= 1'b1;
                  state     <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_START;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - randomized scoreboard bench for instr_fetch_seq
// An instruction-level program model predicts every EXEC beat; a monitor compares them.
module tb_instr_fetch_seq;
   localparam int ADDR_W  = 8;
   localparam int OPC_W   = 7;
   localparam int LIT_W   = 8;
   localparam int INSTR_W = 15;
   localparam logic [OPC_W-1:0] HALT_OPC = 7'h7F;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pc_load, flags_we, alu_z, alu_n, alu_c, alu_v;
   logic [OPC_W-1:0]  opcode;
   logic [LIT_W-1:0]  literal;
   logic              instr_valid;
   logic              Z, N, C, V;
   logic [ADDR_W-1:0] pc;
   logic              halted, fetch_err;

   always #5 clk = ~clk;

   instr_fetch_seq_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imb ();

   instr_fetch_seq dut (
      .clk         (clk),
      .rst         (rst),
      .im          (imb),
      .opcode      (opcode),
      .literal     (literal),
      .instr_valid (instr_valid),
      .pc_load     (pc_load),
      .flags_we    (flags_we),
      .alu_z       (alu_z),
      .alu_n       (alu_n),
      .alu_c       (alu_c),
      .alu_v       (alu_v),
      .Z           (Z),
      .N           (N),
      .C           (C),
      .V           (V),
      .pc          (pc),
      .halted      (halted),
      .fetch_err   (fetch_err)
   );

   typedef struct {
      logic [7:0] addr;
      logic [6:0] opc;
      logic [7:0] lit;
      logic [3:0] flags;
      int         cyc;
   } exp_t;

   int total = 0;
   int bad   = 0;

   exp_t       exp_q[$];
   int         wait_l[$];
   bit         load_l[$];
   bit         fwe_l[$];
   logic [3:0] alu_l[$];

   logic [INSTR_W-1:0] mem [256];
   bit                 mem_set [256];
   logic [7:0]         final_pc, abort_pc;
   logic [3:0]         final_flags;
   int cyc, fi, ei, wcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Program-level model: walks the instruction stream, building memory lazily.
   task automatic gen_run(input int n_min, input bit wrap, input bit abort);
      logic [7:0] p, l;
      logic [6:0] o;
      logic [3:0] f, a;
      int c, w;
      bit ld, fwe;
      exp_q.delete(); wait_l.delete(); load_l.delete(); fwe_l.delete(); alu_l.delete();
      for (int k = 0; k < 256; k++) begin
         mem_set[k] = 1'b0;
         mem[k] = 15'($urandom);
      end
      p = 8'd0; f = 4'd0; c = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!mem_set[p]) begin
            do o = 7'($urandom); while (o == HALT_OPC);
            if (!abort && i >= n_min) o = HALT_OPC;
            l = 8'($urandom);
            if (wrap && i == 0) l = 8'hFD;
            mem[p] = {o, l};
            mem_set[p] = 1'b1;
         end
         if (abort && i == n_min) begin
            wait_l.push_back(1 << 30);
            abort_pc = p;
            break;
         end
         w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         wait_l.push_back(w);
         c += 2 + w;
         o = mem[p][14:8];
         l = mem[p][7:0];
         exp_q.push_back('{addr: p, opc: o, lit: l, flags: f, cyc: c});
         ld  = wrap ? (i == 0) : ($urandom_range(0, 3) == 0);
         fwe = 1'($urandom);
         a   = 4'($urandom);
         if (abort && i == n_min - 1) begin
            fwe = 1'b1;
            a = 4'hF;
         end
         load_l.push_back(ld);
         fwe_l.push_back(fwe);
         alu_l.push_back(a);
         if (fwe) f = a;
         p = ld ? l : p + 8'd1;
         if (o == HALT_OPC) break;
      end
      final_pc = p;
      final_flags = f;
   endtask

   task automatic drive_cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (imb.im_req) begin
         if (fi < wait_l.size() && wcnt >= wait_l[fi]) begin
            imb.im_ack = 1'b1;
            imb.im_rdata = mem[imb.im_addr];
            fi++;
            wcnt = 0;
         end else begin
            imb.im_ack = 1'b0;
            imb.im_rdata = 15'($urandom);
            wcnt++;
         end
      end else begin
         imb.im_ack = 1'($urandom);
         imb.im_rdata = 15'($urandom);
      end
      if (instr_valid && ei < load_l.size()) begin
         pc_load = load_l[ei];
         flags_we = fwe_l[ei];
         {alu_z, alu_n, alu_c, alu_v} = alu_l[ei];
         ei++;
      end else begin
         pc_load = 1'($urandom);
         flags_we = 1'($urandom);
         {alu_z, alu_n, alu_c, alu_v} = 4'($urandom);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      imb.im_ack = 1'b0;
      imb.im_rdata = '0;
      pc_load = 1'b0;
      flags_we = 1'b0;
      {alu_z, alu_n, alu_c, alu_v} = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {imb.im_req, instr_valid, halted, fetch_err, Z, N, C, V,
                          pc, opcode, literal}, 32'd0);
   endtask

   task automatic run_prog(input int n_min, input bit wrap, input bit abort);
      int n;
      gen_run(n_min, wrap, abort);
      apply_reset();
      rst = 1'b0;
      cyc = 0; fi = 0; ei = 0; wcnt = 0;
      n = 0;
      if (!abort) begin
         while (!halted && n < 3000) begin
            drive_cycle();
            n++;
         end
         chk("halt_reached", halted, 1);
         chk("halt_pc", pc, final_pc);
         chk("halt_flags", {Z, N, C, V}, final_flags);
         chk("halt_no_req", imb.im_req, 0);
         chk("halt_no_err", fetch_err, 0);
         chk("exec_left", exp_q.size(), 0);
         repeat (3) begin
            drive_cycle();
            chk("halt_hold", {halted, imb.im_req, instr_valid, pc}, {3'b100, final_pc});
         end
      end else begin
         while ((ei < n_min || exp_q.size() != 0) && n < 3000) begin
            drive_cycle();
            n++;
         end
         chk("abort_progress", ei, n_min);
         repeat (20) drive_cycle();
`ifdef FETCH_TIMEOUT_EN
         chk("tmo_state", {fetch_err, halted, imb.im_req, instr_valid}, 4'b1100);
         chk("tmo_pc", pc, abort_pc);
`else
         chk("stall_state", {fetch_err, halted, imb.im_req, instr_valid}, 4'b0010);
         chk("stall_addr", imb.im_addr, abort_pc);
`endif
         chk("stall_flags", {Z, N, C, V}, 4'hF);
         rst = 1'b1;
         @(posedge clk);
         #1;
         chk("midfetch_reset", {imb.im_req, instr_valid, halted, fetch_err, Z, N, C, V, pc},
             32'd0);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && instr_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_exec", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("exec_pc", pc, e.addr);
               chk("exec_opcode", opcode, e.opc);
               chk("exec_literal", literal, e.lit);
               chk("exec_flags", {Z, N, C, V}, e.flags);
               chk("exec_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      run_prog(6, 1'b1, 1'b0);
      for (int r = 0; r < 8; r++) run_prog(int'($urandom_range(4, 25)), 1'b0, 1'b0);
      run_prog(5, 1'b0, 1'b1);
      apply_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
